// File: rtl/axi_filter_range_ctrl.sv
// Shadow/active START/STOP range registers for the AXI address filters, with a drain-then-commit FSM.
// Register access: response 1 cycle after grant. Commit: >=3 cycles. Writes stall while a commit is in flight.
module axi_filter_range_ctrl #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NBR_RANGE      = 4,
  parameter int DRAIN_TIMEOUT  = 1024
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         cfg_req_i,
  input  logic                                         cfg_we_i,
  input  logic [7:0]                                   cfg_addr_i,
  input  logic [31:0]                                  cfg_wdata_i,
  output logic                                         cfg_gnt_o,
  output logic                                         cfg_rvalid_o,
  output logic [31:0]                                  cfg_rdata_o,
  output logic                                         cfg_err_o,
  input  logic                                         filter_busy_i,
  output logic                                         filter_hold_o,
  output logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]     START_ADDR_o,
  output logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]     STOP_ADDR_o,
  output logic                                         locked_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam int CW = $clog2(DRAIN_TIMEOUT);

  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic          lock_q;
  logic          tmo_q;
  logic          bad_q;
  logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] sh_start_q;
  logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] sh_stop_q;

  logic [5:0]  widx;
  logic [5:0]  roff;
  logic [2:0]  rsel;
  logic        is_stop;
  logic        is_ctrl;
  logic        is_status;
  logic        is_range;
  logic        err_c;
  logic        gnt;
  logic        wr_ok;
  logic        commit_go;
  logic        overlap;
  logic [31:0] rd_c;

  // Word index decode; range registers occupy pairs starting at word 4.
  assign widx      = cfg_addr_i[7:2];
  assign roff      = widx - 6'd4;
  assign rsel      = roff[3:1];
  assign is_stop   = roff[0];
  assign is_ctrl   = (widx == 6'd0);
  assign is_status = (widx == 6'd1);
  assign is_range  = (widx >= 6'd4) && (widx < 6'(4 + 2 * NBR_RANGE));

  assign err_c     = ~(is_ctrl | is_status | is_range) |
                     (cfg_we_i & lock_q & (is_ctrl | is_range));
  assign gnt       = cfg_req_i & (~cfg_we_i | (state_q == ST_IDLE));
  assign wr_ok     = gnt & cfg_we_i & ~err_c;
  assign commit_go = wr_ok & is_ctrl & cfg_wdata_i[0];

  logic unused_bits;
  assign unused_bits = ^{cfg_addr_i[1:0], roff[5:4], cfg_wdata_i};

  always_comb begin
    rd_c = '0;
    if (is_status) begin
      rd_c = {28'd0, bad_q, tmo_q, lock_q, (state_q != ST_IDLE)};
    end else if (is_range) begin
      for (int i = 0; i < NBR_RANGE; i++) begin
        if (rsel == 3'(i)) begin
          rd_c = is_stop ? 32'(sh_stop_q[i]) : 32'(sh_start_q[i]);
        end
      end
    end
  end

  // Only enabled ranges (START <= STOP) can conflict.
  always_comb begin
    overlap = 1'b0;
    for (int i = 0; i < NBR_RANGE; i++) begin
      for (int j = i + 1; j < NBR_RANGE; j++) begin
        if ((sh_start_q[i] <= sh_stop_q[i]) && (sh_start_q[j] <= sh_stop_q[j]) &&
            (sh_start_q[i] <= sh_stop_q[j]) && (sh_start_q[j] <= sh_stop_q[i])) begin
          overlap = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lock_q       <= 1'b0;
      tmo_q        <= 1'b0;
      bad_q        <= 1'b0;
      sh_start_q   <= '1;
      sh_stop_q    <= '0;
      START_ADDR_o <= '1;
      STOP_ADDR_o  <= '0;
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= gnt;
      cfg_err_o    <= gnt & err_c;
      cfg_rdata_o  <= (gnt & ~cfg_we_i & ~err_c) ? rd_c : '0;

      if (wr_ok && is_range) begin
        for (int i = 0; i < NBR_RANGE; i++) begin
          if (rsel == 3'(i)) begin
            if (is_stop) sh_stop_q[i]  <= cfg_wdata_i[AXI_ADDR_WIDTH-1:0];
            else         sh_start_q[i] <= cfg_wdata_i[AXI_ADDR_WIDTH-1:0];
          end
        end
      end
      if (wr_ok && is_ctrl && cfg_wdata_i[1]) lock_q <= 1'b1;
      if (wr_ok && is_status) begin
        if (cfg_wdata_i[2]) tmo_q <= 1'b0;
        if (cfg_wdata_i[3]) bad_q <= 1'b0;
      end

      // Sticky sets below are placed after the W1C clears so a set wins.
      case (state_q)
        ST_IDLE: begin
          if (commit_go) begin
            if (overlap) begin
              bad_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
              cnt_q   <= '0;
            end
          end
        end
        ST_DRAIN: begin
          cnt_q <= cnt_q + CW'(1);
          if (!filter_busy_i) begin
            state_q <= ST_COMMIT;
          end else if (cnt_q == CW'(DRAIN_TIMEOUT - 1)) begin
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          START_ADDR_o <= sh_start_q;
          STOP_ADDR_o  <= sh_stop_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_gnt_o     = gnt;
  assign filter_hold_o = (state_q != ST_IDLE);
  assign locked_o      = lock_q;

endmodule

// File: tb/tb_axi_filter_range_ctrl.sv
// Directed bench for axi_filter_range_ctrl: register access, drain/commit, timeout, overlap, lock, reset.
module tb_axi_filter_range_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic [7:0]        addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;
  logic              busy;
  logic              hold;
  logic [3:0][31:0]  start_addr;
  logic [3:0][31:0]  stop_addr;
  logic              locked;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        rerr;

  always #5 clk = ~clk;

  axi_filter_range_ctrl #(
    .AXI_ADDR_WIDTH(32),
    .NBR_RANGE(4),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .cfg_req_i(req),
    .cfg_we_i(we),
    .cfg_addr_i(addr),
    .cfg_wdata_i(wdata),
    .cfg_gnt_o(gnt),
    .cfg_rvalid_o(rvalid),
    .cfg_rdata_o(rdata),
    .cfg_err_o(err),
    .filter_busy_i(busy),
    .filter_hold_o(hold),
    .START_ADDR_o(start_addr),
    .STOP_ADDR_o(stop_addr),
    .locked_o(locked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one access at a negedge, wait (bounded) for grant, return the response from cycle T+1.
  // Returns at the negedge inside cycle T+1.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] r, output logic e);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    n = 0;
    while (!gnt && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!gnt) begin
      check("gnt_timeout", 32'd0, 32'd1);
      req = 1'b0;
      r = '0;
      e = 1'b1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check("rvalid", 32'(rvalid), 32'd1);
      r = rdata;
      e = err;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    xfer(1'b1, a, d, rd, rerr);
    check("wr_err", 32'(rerr), 32'(exp_err));
    check("wr_rdata", rd, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp,
                        input logic exp_err);
    xfer(1'b0, a, 32'd0, rd, rerr);
    check(tag, rd, exp);
    check("rd_err", 32'(rerr), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; busy = 1'b0;
    do_reset();

    // Reset state
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_start0", start_addr[0], 32'hFFFF_FFFF);
    check("rst_stop0", stop_addr[0], 32'h0);
    rd_chk("rst_sh_start0", 8'h10, 32'hFFFF_FFFF, 1'b0);
    rd_chk("rst_sh_stop0", 8'h14, 32'h0, 1'b0);
    rd_chk("rst_status", 8'h04, 32'h0, 1'b0);

    // Basic commit with no outstanding traffic
    wr(8'h10, 32'h1000_0000, 1'b0);
    wr(8'h14, 32'h1000_FFFF, 1'b0);
    rd_chk("sh_stop0_rb", 8'h14, 32'h1000_FFFF, 1'b0);
    wr(8'h00, 32'h1, 1'b0);
    check("c1_hold_t1", 32'(hold), 32'd1);
    @(negedge clk);
    check("c1_hold_t2", 32'(hold), 32'd1);
    check("c1_start0_t2", start_addr[0], 32'hFFFF_FFFF);
    @(negedge clk);
    check("c1_hold_t3", 32'(hold), 32'd0);
    check("c1_start0_t3", start_addr[0], 32'h1000_0000);
    check("c1_stop0_t3", stop_addr[0], 32'h1000_FFFF);
    rd_chk("c1_status", 8'h04, 32'h0, 1'b0);

    // Commit held off by outstanding transactions; writes stall, reads pass
    wr(8'h18, 32'h2000_0000, 1'b0);
    wr(8'h1C, 32'h2000_0FFF, 1'b0);
    busy = 1'b1;
    wr(8'h00, 32'h1, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("c2_wr_stall_gnt", 32'(gnt), 32'd0);
      check("c2_hold", 32'(hold), 32'd1);
      @(negedge clk);
    end
    req = 1'b0;
    rd_chk("c2_status_pending", 8'h04, 32'h1, 1'b0);
    busy = 1'b0;
    @(negedge clk);
    check("c2_hold_d1", 32'(hold), 32'd1);
    check("c2_start1_d1", start_addr[1], 32'hFFFF_FFFF);
    @(negedge clk);
    check("c2_hold_d2", 32'(hold), 32'd0);
    check("c2_start1_d2", start_addr[1], 32'h2000_0000);
    check("c2_stop1_d2", stop_addr[1], 32'h2000_0FFF);
    rd_chk("c2_sh_start2_untouched", 8'h20, 32'hFFFF_FFFF, 1'b0);

    // Drain timeout: 16 DRAIN cycles then abort
    wr(8'h20, 32'h3000_0000, 1'b0);
    wr(8'h24, 32'h3000_00FF, 1'b0);
    busy = 1'b1;
    wr(8'h00, 32'h1, 1'b0);
    repeat (15) @(negedge clk);
    check("tmo_hold_last", 32'(hold), 32'd1);
    @(negedge clk);
    check("tmo_hold_exit", 32'(hold), 32'd0);
    check("tmo_start2", start_addr[2], 32'hFFFF_FFFF);
    busy = 1'b0;
    rd_chk("tmo_status", 8'h04, 32'h4, 1'b0);
    wr(8'h04, 32'h4, 1'b0);
    rd_chk("tmo_clear", 8'h04, 32'h0, 1'b0);

    // Overlapping enabled ranges refuse the commit
    wr(8'h10, 32'h0000_0100, 1'b0);
    wr(8'h14, 32'h0000_01FF, 1'b0);
    wr(8'h18, 32'h0000_0180, 1'b0);
    wr(8'h1C, 32'h0000_02FF, 1'b0);
    wr(8'h00, 32'h1, 1'b0);
    check("ovl_hold", 32'(hold), 32'd0);
    @(negedge clk);
    check("ovl_hold2", 32'(hold), 32'd0);
    check("ovl_start0", start_addr[0], 32'h1000_0000);
    check("ovl_start1", start_addr[1], 32'h2000_0000);
    rd_chk("ovl_status", 8'h04, 32'h8, 1'b0);
    wr(8'h04, 32'h8, 1'b0);
    rd_chk("ovl_clear", 8'h04, 32'h0, 1'b0);

    // Commit + lock together
    wr(8'h18, 32'h0000_0200, 1'b0);
    wr(8'h00, 32'h3, 1'b0);
    check("lk_locked", 32'(locked), 32'd1);
    check("lk_hold_t1", 32'(hold), 32'd1);
    repeat (2) @(negedge clk);
    check("lk_hold_t3", 32'(hold), 32'd0);
    check("lk_start0", start_addr[0], 32'h0000_0100);
    check("lk_start1", start_addr[1], 32'h0000_0200);
    check("lk_stop1", stop_addr[1], 32'h0000_02FF);
    rd_chk("lk_status", 8'h04, 32'h2, 1'b0);
    wr(8'h10, 32'h0000_5555, 1'b1);
    rd_chk("lk_sh_start0", 8'h10, 32'h0000_0100, 1'b0);
    wr(8'h00, 32'h1, 1'b1);
    check("lk_no_commit_hold", 32'(hold), 32'd0);
    wr(8'h04, 32'hC, 1'b0);
    rd_chk("lk_ctrl_reads0", 8'h00, 32'h0, 1'b0);

    // Unmapped addresses
    rd_chk("unmap_08", 8'h08, 32'h0, 1'b1);
    rd_chk("unmap_30", 8'h30, 32'h0, 1'b1);
    rd_chk("stop3_last", 8'h2C, 32'h0, 1'b0);

    // Reset during DRAIN
    do_reset();
    check("rst2_locked", 32'(locked), 32'd0);
    check("rst2_start0", start_addr[0], 32'hFFFF_FFFF);
    wr(8'h10, 32'h0000_4000, 1'b0);
    wr(8'h14, 32'h0000_4FFF, 1'b0);
    wr(8'h00, 32'h1, 1'b0);
    repeat (2) @(negedge clk);
    check("rst3_start0_pre", start_addr[0], 32'h0000_4000);
    wr(8'h10, 32'h0000_6000, 1'b0);
    busy = 1'b1;
    wr(8'h00, 32'h1, 1'b0);
    check("rst3_hold_drain", 32'(hold), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst3_hold", 32'(hold), 32'd0);
    check("rst3_start0", start_addr[0], 32'hFFFF_FFFF);
    check("rst3_stop0", stop_addr[0], 32'h0);
    rst = 1'b0;
    busy = 1'b0;
    rd_chk("rst3_sh_start0", 8'h10, 32'hFFFF_FFFF, 1'b0);
    rd_chk("rst3_status", 8'h04, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_filter_range_ctrl.md
# axi_filter_range_ctrl

Programmable configuration controller for the AXI address-range filters. It holds a shadow copy of the per-range START/STOP addresses written over a simple req/gnt register port. On a commit request it stalls new AR/AW acceptance at the filters, waits until every outstanding transaction has drained, and then atomically loads the shadow into the active range outputs. A sticky lock bit freezes the configuration, and a drain timeout aborts a commit that cannot complete.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, width of range addresses; must be ≤ 32.
- NBR_RANGE, 4, number of filter ranges; 1..8.
- DRAIN_TIMEOUT, 1024, maximum number of cycles spent in DRAIN before the commit aborts; ≥ 2.

Ports:
- i_clk  in  1  single clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- cfg_req_i  in  1  register access request.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_addr_i  in  8  byte address; bits [1:0] are ignored.
- cfg_wdata_i  in  32  write data.
- cfg_gnt_o  out  1  access accepted this cycle.
- cfg_rvalid_o  out  1  response valid, one cycle after a grant.
- cfg_rdata_o  out  32  read data; 0 for writes and errors.
- cfg_err_o  out  1  error response, qualified by cfg_rvalid_o.
- filter_busy_i  in  1  OR of "outstanding transactions non-empty" from all filter channels.
- filter_hold_o  out  1  when 1, the filters must not accept new AR/AW.
- START_ADDR_o  out  AXI_ADDR_WIDTH x NBR_RANGE  active range start addresses.
- STOP_ADDR_o  out  AXI_ADDR_WIDTH x NBR_RANGE  active range stop addresses.
- locked_o  out  1  mirror of LOCK.

## Operation
Register map:
- 0x00 CTRL (write-only, reads 0):
  - bit0 COMMIT: write 1 to start a commit.
  - bit1 LOCK: write 1 to set; sticky until reset.
- 0x04 STATUS:
  - bit0 PENDING (RO): state ≠ IDLE.
  - bit1 LOCKED (RO).
  - bit2 TMO: sticky; write 1 to clear.
  - bit3 BADCFG: sticky; write 1 to clear.
- 0x10+8·i: shadow START[i]. 0x14+8·i: shadow STOP[i]. Both RW and zero-extended to 32 bits on read.

Error responses (cfg_err_o=1, no register effect):
- Unmapped address.
- Any write to CTRL or to a START/STOP register while LOCKED. STATUS W1C writes are still allowed.

Reset and range encoding:
- Reset value of every shadow and active range: START = all ones, STOP = 0, i.e. disabled (never in range).
- A range with START > STOP is a valid "disabled" encoding.
- BADCFG is set, and the commit is refused, only if two enabled ranges overlap.

Commit FSM:
- IDLE:
  - An accepted CTRL write with bit0=1 runs the overlap check.
  - If the check fails: set BADCFG and stay in IDLE.
  - Otherwise go to DRAIN and clear the timeout counter.
- DRAIN:
  - filter_hold_o = 1.
  - The counter increments every cycle.
  - If filter_busy_i = 0, go to COMMIT.
  - Else, if the counter = DRAIN_TIMEOUT-1, set TMO and go to IDLE without committing.
- COMMIT:
  - filter_hold_o = 1.
  - Active ranges are loaded from the shadow at the end of this cycle.
  - Go to IDLE.

Grant rules:
- cfg_gnt_o = cfg_req_i, except that writes are not granted (stall) while state ≠ IDLE.
- Reads are always granted.

Simultaneous events:
- A CTRL write with bit0=1 and bit1=1: the commit proceeds and LOCK is set in the same cycle.
- A W1C of TMO in the same cycle as a timeout: the set wins.

## Timing
- Reset outputs: cfg_gnt_o=0, cfg_rvalid_o=0, cfg_rdata_o=0, cfg_err_o=0, filter_hold_o=0, locked_o=0, active ranges disabled, state IDLE.
- Register access: grant in cycle T; cfg_rvalid_o/cfg_rdata_o/cfg_err_o are registered and valid in T+1 for exactly one cycle. Back-to-back accesses are allowed.
- Commit latency:
  - COMMIT write granted at T.
  - DRAIN and filter_hold_o=1 from T+1.
  - filter_busy_i is first sampled at T+1, which covers any transaction accepted at T.
  - If busy is low at D (D ≥ T+1), COMMIT is at D+1.
  - New active ranges and filter_hold_o=0 are at D+2.
  - Minimum total latency: 3 cycles.
- filter_hold_o is decoded from registered state only; it has no combinational path from the cfg inputs.
- Active range outputs are registered and change only on the COMMIT cycle edge or on reset.
- Reset asserted mid-DRAIN or mid-COMMIT: next cycle the state is IDLE, hold=0, ranges are disabled, and the shadow is reset.

## Test plan
- Reset, then read 0x10 and 0x14 -> rdata 0xFFFF_FFFF and 0x0000_0000; START_ADDR_o[0]=all ones.
- Write START0=0x1000_0000, STOP0=0x1000_FFFF, then CTRL=1 with filter_busy_i=0 -> hold high for 2 cycles; START_ADDR_o[0]=0x1000_0000 three cycles after the grant.
- Commit with filter_busy_i=1 for 10 cycles -> hold stays high and a write issued during this time is stalled (gnt=0); the commit lands 2 cycles after busy falls.
- filter_busy_i held at 1, DRAIN_TIMEOUT=16 -> after 16 DRAIN cycles: TMO=1, hold=0, active ranges unchanged; writing STATUS=0x4 clears TMO.
- Overlap: range0 = 0x100–0x1FF and range1 = 0x180–0x2FF, then CTRL=1 -> BADCFG=1, no hold, outputs unchanged.
- CTRL=0x3 -> the commit completes and LOCKED=1; a subsequent START0 write returns err=1 and its value is unchanged; asserting i_rst mid-DRAIN returns to the reset state.
